// File: rtl/lvds_host_seq.sv
// Host-side transaction sequencer for the LVDS remote-IO link: forwards one command
// to lvds_io, waits for the marked read-back frame or a timeout, and returns the result.
module lvds_host_seq #(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [33:0] MARKER  = 34'h3CAFEFEED
) (
  input  logic        c,
  input  logic        r,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [39:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] bad_frames,
  output logic        tx_valid,
  output logic [65:0] tx_data,
  input  logic        rx_valid,
  input  logic [65:0] rx_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] timer;
  logic        marker_ok;
  logic        frame_bad;

  always_comb begin
    marker_ok = (rx_data[65:32] == MARKER);
    frame_bad = rx_valid && !(state == WAIT && marker_ok);
  end

  // timer counts cycles since the tx_valid cycle, so the timeout response
  // appears exactly TIMEOUT cycles after the issue pulse
  always_ff @(posedge c) begin
    if (r) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      bad_frames  <= '0;
      timer       <= '0;
    end else begin
      if (frame_bad && bad_frames != '1)
        bad_frames <= bad_frames + 16'd1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            tx_valid  <= 1'b1;
            tx_data   <= {26'h0, cmd_data};
            timer     <= '0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          tx_valid <= 1'b0;
          timer    <= timer + 16'd1;
          state    <= WAIT;
        end
        WAIT: begin
          timer <= timer + 16'd1;
          if (rx_valid && marker_ok) begin
            rsp_data    <= rx_data[31:0];
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (timer == TLAST) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_host_seq.sv
// Scoreboard bench for lvds_host_seq: a driver plays host and target, a monitor
// checks tx pulses and responses against expectations queued by the driver.
module tb_lvds_host_seq;

  localparam int unsigned TO = 1023;
  localparam logic [33:0] MK = 34'h3CAFEFEED;

  logic        c = 1'b0;
  logic        r = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [39:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;
  logic [15:0] bad_frames;
  logic        tx_valid;
  logic [65:0] tx_data;
  logic        rx_valid = 1'b0;
  logic [65:0] rx_data = '0;

  lvds_host_seq #(.TIMEOUT(TO), .MARKER(MK)) dut (
    .c(c), .r(r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy), .bad_frames(bad_frames),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 c = ~c;

  int unsigned cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic to; int unsigned cyc; } rsp_t;
  typedef struct { logic [65:0] data; int unsigned cyc; } tx_t;

  rsp_t        rsp_q[$];
  tx_t         tx_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_bad = 0;
  int unsigned rsp_done = 0;
  int          ready_mode = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    #900000;
    abort("global_time_limit");
  end

  // consumer side of the response interface
  initial forever begin
    @(posedge c);
    #2;
    case (ready_mode)
      0:       rsp_ready = ($urandom_range(0, 2) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // monitor
  logic prev_v = 1'b0, prev_rdy = 1'b0, busy_exp = 1'b0;
  rsp_t cur;
  tx_t  tx_e;
  int   hold_bad = 0, busy_bad = 0;

  initial forever begin
    @(negedge c);
    if (r) begin
      prev_v   = 1'b0;
      prev_rdy = 1'b0;
      busy_exp = 1'b0;
    end else begin
      if (tx_valid) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          tx_e = tx_q.pop_front();
          chk("tx_data", tx_data, tx_e.data);
          chk("tx_cycle", cyc, tx_e.cyc);
          busy_exp = 1'b1;
        end
      end
      if (busy !== busy_exp) busy_bad++;
      if (rsp_valid && !(prev_v && !prev_rdy)) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          cur = rsp_q.pop_front();
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_timeout", rsp_timeout, cur.to);
          chk("rsp_cycle", cyc, cur.cyc);
          hold_bad = 0;
        end
      end else if (rsp_valid) begin
        if (rsp_data !== cur.data || rsp_timeout !== cur.to) hold_bad++;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_stable", hold_bad, 0);
        chk("busy_track", busy_bad, 0);
        busy_bad = 0;
        busy_exp = 1'b0;
        rsp_done++;
      end
      prev_v   = rsp_valid;
      prev_rdy = rsp_ready;
    end
  end

  task automatic chk_reset();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_bad_frames", bad_frames, 0);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic send_frame(input int unsigned at, input logic [65:0] d, input logic bad);
    wait_cyc(at);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge c);
    #1;
    rx_valid = 1'b0;
    if (bad) exp_bad++;
  endtask

  task automatic issue(input logic [39:0] cmd, output int unsigned t);
    int unsigned n = 0;
    tx_t e;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    forever begin
      @(negedge c);
      if (cmd_ready) break;
      n++;
      if (n > 3000) abort("cmd_ready_wait");
    end
    t = cyc + 1;
    e.data = {26'h0, cmd};
    e.cyc  = t;
    tx_q.push_back(e);
    @(posedge c);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target);
    int unsigned n = 0;
    while (rsp_done < target) begin
      @(negedge c);
      n++;
      if (n > 3000) abort("rsp_handshake_wait");
    end
    @(posedge c);
    #1;
  endtask

  // mode 0: good reply at issue+d, 1: no reply, 2: bad frame at issue+b then good at issue+d
  // a reply is taken only if it lands 1..TO-1 cycles after the issue cycle
  task automatic expect_and_reply(input int unsigned t, input int mode, input int unsigned d,
                                  input int unsigned b, input logic [33:0] bm,
                                  input logic [31:0] data, input int unsigned target);
    rsp_t e;
    if (mode != 1 && d >= 1 && d < TO) begin
      e.data = data; e.to = 1'b0; e.cyc = t + d + 1;
    end else begin
      e.data = '0;   e.to = 1'b1; e.cyc = t + TO;
    end
    rsp_q.push_back(e);
    if (mode == 2) send_frame(t + b, {bm, 32'($urandom)}, 1'b1);
    if (mode != 1) send_frame(t + d, {MK, data}, d >= TO);
    wait_done(target);
    @(negedge c);
    chk("bad_frames", bad_frames, exp_bad);
    @(posedge c);
    #1;
  endtask

  task automatic txn(input logic [39:0] cmd, input int mode, input int unsigned d,
                     input int unsigned b, input logic [33:0] bm, input logic [31:0] data);
    int unsigned t, done0;
    done0 = rsp_done;
    issue(cmd, t);
    expect_and_reply(t, mode, d, b, bm, data, done0 + 1);
  endtask

  initial begin
    int unsigned t, t2, h, n, done0, viol, d, b;
    int mode;
    logic [33:0] bm;

    repeat (3) @(posedge c);
    @(negedge c);
    chk_reset();
    @(posedge c);
    #1;
    r = 1'b0;

    txn(40'h12_DEADBEEF, 0, 300, 0, '0, 32'hA5A5_0001);
    txn(40'h00_00000055, 1, 0, 0, '0, '0);
    txn(40'h34_01020304, 2, 300, 100, 34'h0, 32'h0000_0001);
    txn(40'h56_CAFEF00D, 0, TO - 1, 0, '0, 32'h7777_1234);

    // response held off while the next command waits
    done0 = rsp_done;
    ready_mode = 1;
    issue(40'h11_11111111, t);
    expect_and_reply_async : begin
      rsp_t e;
      e.data = 32'h5A5A_0F0F; e.to = 1'b0; e.cyc = t + 301;
      rsp_q.push_back(e);
    end
    send_frame(t + 300, {MK, 32'h5A5A_0F0F}, 1'b0);
    n = 0;
    while (!rsp_valid) begin
      @(negedge c);
      n++;
      if (n > 3000) abort("rsp_valid_wait");
    end
    @(posedge c);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = 40'h22_22222222;
    viol = 0;
    repeat (50) begin
      @(negedge c);
      if (cmd_ready || tx_valid || !rsp_valid) viol++;
    end
    chk("hold_stall", viol, 0);
    @(posedge c);
    #1;
    ready_mode = 2;
    h = cyc;
    issue(40'h22_22222222, t2);
    chk("turnaround", t2, h + 2);
    expect_and_reply(t2, 0, 260, 0, '0, 32'hBEEF_0002, done0 + 2);
    ready_mode = 0;

    // reset while waiting, then the stale reply arrives
    issue(40'h33_33333333, t);
    wait_cyc(t + 50);
    r = 1'b1;
    exp_bad = 0;
    @(posedge c);
    #1;
    r = 1'b0;
    @(negedge c);
    chk_reset();
    @(posedge c);
    #1;
    send_frame(t + 300, {MK, 32'h0000_1234}, 1'b1);
    viol = 0;
    repeat (20) begin
      @(negedge c);
      if (rsp_valid) viol++;
    end
    chk("rst_no_rsp", viol, 0);
    chk("rst_late_bad", bad_frames, exp_bad);
    @(posedge c);
    #1;

    for (int i = 0; i < 10; i++) begin
      mode = int'($urandom_range(0, 4));
      b  = 0;
      bm = {2'($urandom), 32'($urandom)};
      if (bm == MK) bm = bm ^ 34'h1;
      case (mode)
        0: d = $urandom_range(1, 700);
        1: d = 0;
        2: begin b = $urandom_range(1, 200); d = $urandom_range(b + 1, 700); end
        3: d = $urandom_range(TO, TO + 5);
        default: d = $urandom_range(TO - 2, TO - 1);
      endcase
      txn({8'($urandom), 32'($urandom)}, (mode >= 3) ? 0 : mode, d, b, bm, 32'($urandom));
    end

    chk("rsp_queue_empty", rsp_q.size(), 0);
    chk("tx_queue_empty", tx_q.size(), 0);
    chk("busy_final", busy_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
